// File: rtl/cprv_pkg.sv
// Shared types and constants for the CPU data-memory interface.
package cprv_pkg;

    localparam int CPRV_DATA_WIDTH       = 64;
    localparam int CPRV_ADDR_WIDTH       = 7;
    localparam int CPRV_DMEM_MAX_LATENCY = 4;

    // One request as presented on the dmem request channel.
    typedef struct packed {
        logic [CPRV_ADDR_WIDTH-1:0] addr;
        logic [CPRV_DATA_WIDTH-1:0] wdata;
        logic                       w_en;
    } dmem_req_t;

    // One response: read data, or the write data echoed as the acknowledge.
    typedef struct packed {
        logic [CPRV_DATA_WIDTH-1:0] rdata;
    } dmem_resp_t;

    // Pointer width for a circular buffer of the given depth (at least 1 bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cprv_resp_fifo.sv
// In-order response buffer. The head entry is held in a register so the
// output stays stable while waiting and keeps its last value when empty.
module cprv_resp_fifo
    import cprv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  dmem_resp_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output dmem_resp_t head
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    dmem_resp_t      slots [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Next read pointer and occupancy after this edge.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt + CW'(push) - CW'(pop);
        if (pop) rd_ptr_nxt = wrap_inc(rd_ptr);
    end

    // Pointer, occupancy and head-register update.
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
            // New head is the pushed entry when nothing else remains ahead of it.
            if (cnt_nxt != '0)
                head <= (push && cnt == CW'(pop)) ? push_data : slots[rd_ptr_nxt];
        end
    end

    // Slot storage write.
    // NOTE: storage arrays are not reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cprv_dmem_responder.sv
// Data-memory responder: word-addressed storage behind a valid/ready request
// channel, fixed-latency pipeline and a bounded in-order response buffer.
module cprv_dmem_responder
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = CPRV_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPRV_ADDR_WIDTH,
    parameter int LATENCY    = 1,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_dmem_i,
    output logic                  ready_dmem_o,
    input  logic [ADDR_WIDTH-1:0] addr_dmem_i,
    input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
    input  logic                  w_en_dmem_i,
    output logic                  valid_mem_dmem_o,
    input  logic                  ready_mem_dmem_i,
    output logic [DATA_WIDTH-1:0] rdata_dmem_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(RESP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    dmem_req_t             req;
    logic                  accept;
    logic                  resp_pop;
    logic [CW-1:0]         count;
    logic [LATENCY-1:0]    pipe_valid;
    dmem_resp_t            pipe_data [LATENCY];
    logic                  fifo_full;
    logic                  fifo_empty;
    dmem_resp_t            fifo_head;

    assign req = '{addr: addr_dmem_i, wdata: wdata_dmem_i, w_en: w_en_dmem_i};

    assign resp_pop         = valid_mem_dmem_o && ready_mem_dmem_i;
    // A pop frees a slot in the same cycle, so a full buffer still accepts.
    // fifo_full implies count == RESP_DEPTH; it is kept as a direct guard.
    assign ready_dmem_o     = !rst && ((count < CW'(RESP_DEPTH) && !fifo_full) || resp_pop);
    assign accept           = valid_dmem_i && ready_dmem_o;
    assign valid_mem_dmem_o = !fifo_empty;
    assign rdata_dmem_o     = fifo_head.rdata;

    // Outstanding-response counter: accepted but not yet popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({accept, resp_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Valid shift pipeline; in-flight requests are discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    // Storage write and data pipeline: a read samples the array at its accept edge.
    always_ff @(posedge clk) begin
        if (accept && req.w_en) mem[req.addr] <= req.wdata;
        pipe_data[0].rdata <= req.w_en ? req.wdata : mem[req.addr];
        for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    end

    cprv_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid[LATENCY-1]),
        .push_data (pipe_data[LATENCY-1]),
        .pop       (resp_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_cprv_dmem_responder.sv
// Self-checking bench for cprv_dmem_responder with a transaction-level model:
// an array for storage and a queue of pending responses with visibility times.
module tb_cprv_dmem_responder;

    localparam int LAT = 1;
    localparam int RD  = 2;
    localparam int AW  = 7;
    localparam int DW  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          w_en;
    logic          valid_r;
    logic          ready_r;
    logic [DW-1:0] rdata;

    cprv_dmem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT),
        .RESP_DEPTH (RD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_dmem_i     (valid_i),
        .ready_dmem_o     (ready_o),
        .addr_dmem_i      (addr),
        .wdata_dmem_i     (wdata),
        .w_en_dmem_i      (w_en),
        .valid_mem_dmem_o (valid_r),
        .ready_mem_dmem_i (ready_r),
        .rdata_dmem_o     (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            vis;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] mmem [2**AW];
    logic [DW-1:0] last_r;
    int            cyc;
    int            total = 0;
    int            bad   = 0;
    logic          obs_valid, obs_ready;
    logic [DW-1:0] obs_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance model at posedge.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic w, input logic rm, output logic acc);
        logic          exp_valid, exp_ready;
        logic [DW-1:0] exp_data;
        ent_t          e;
        @(negedge clk);
        valid_i = v; addr = a; wdata = d; w_en = w; ready_r = rm;
        #1;
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        exp_data  = exp_valid ? q[0].data : last_r;
        exp_ready = (q.size() < RD) || (exp_valid && rm);
        obs_valid = valid_r; obs_ready = ready_o; obs_data = rdata;
        chk("resp_valid", 64'(obs_valid), 64'(exp_valid));
        chk("req_ready",  64'(obs_ready), 64'(exp_ready));
        chk("resp_rdata", obs_data, exp_data);
        @(posedge clk);
        cyc++;
        if (exp_valid && rm) begin
            last_r = q[0].data;
            void'(q.pop_front());
        end
        acc = v && exp_ready;
        if (acc) begin
            e.data = w ? d : mmem[a];
            if (w) mmem[a] = d;
            e.vis = cyc + LAT;
            q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   n_acc, lat, hits;
        rst = 1'b1; valid_i = 1'b0; addr = '0; wdata = '0; w_en = 1'b0; ready_r = 1'b0;
        cyc = 0; last_r = '0;

        // Reset state
        #3;
        chk("rst_valid", 64'(valid_r), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Preload every word so all later reads have a known expectation
        for (int i = 0; i < 2**AW; i++)
            step(1'b1, AW'(i), {$urandom(), $urandom()}, 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Write then back-to-back read of addr 5; second matching response after LATENCY
        step(1'b1, 7'd5, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b1, acc);
        step(1'b1, 7'd5, 64'd0, 1'b0, 1'b1, acc);
        lat = 99; hits = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (obs_valid && obs_data == 64'hDEADBEEF_CAFEF00D) begin
                hits++;
                if (hits == 2 && lat == 99) lat = k;
            end
        end
        chk("read_latency", 64'(lat), 64'(LAT));

        // Backpressure: three reads with the response side stalled
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, AW'(10 + i), '0, 1'b0, 1'b0, acc);
            if (obs_ready) n_acc++;
        end
        chk("stall_accepts", 64'(n_acc), 64'd2);
        chk("stall_ready_low", 64'(obs_ready), 64'd0);
        step(1'b1, 7'd12, '0, 1'b0, 1'b1, acc);
        chk("accept_in_pop_cycle", 64'(obs_ready), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Streaming reads of 0..7 at full throughput
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, AW'(i), '0, 1'b0, 1'b1, acc);
            if (obs_ready) n_acc++;
        end
        chk("stream_accepts", 64'(n_acc), 64'd8);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Full buffer with simultaneous accept and pop over many pointer wraps
        step(1'b1, 7'd20, '0, 1'b0, 1'b0, acc);
        step(1'b1, 7'd21, '0, 1'b0, 1'b0, acc);
        n_acc = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, AW'($urandom_range(0, 127)), '0, 1'b0, 1'b1, acc);
            if (obs_ready) n_acc++;
        end
        chk("full_accept_pop", 64'(n_acc), 64'd24);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Address extremes do not alias
        step(1'b1, 7'd127, 64'd1, 1'b1, 1'b1, acc);
        step(1'b1, 7'd0,   64'd2, 1'b1, 1'b1, acc);
        step(1'b1, 7'd127, 64'd0, 1'b0, 1'b1, acc);
        step(1'b1, 7'd0,   64'd0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Randomized traffic with random backpressure on both sides
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 127)),
                 {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, acc);

        // Reset with requests in flight: outputs clear immediately, nothing stale afterwards
        step(1'b1, 7'd30, '0, 1'b0, 1'b0, acc);
        step(1'b1, 7'd31, '0, 1'b0, 1'b0, acc);
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(valid_r), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_rdata", rdata, 64'd0);
        q.delete();
        last_r = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        step(1'b1, 7'd0, '0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
